// File: rtl/ps2_cmd_decoder_if.sv
// Purpose: bundles the scan-code input, write handshake and status outputs of the PS/2 command decoder.
// Latency: none, signal bundle only.
// Backpressure: the WR_REQ/WR_ACK level handshake stalls the decoder; scan codes have no backpressure.
interface ps2_cmd_decoder_if;
  logic [7:0] SCAN_CODE;
  logic       SCAN_VALID;
  logic       WR_ACK;
  logic       EDIT_MODE;
  logic [2:0] FIELD_SEL;
  logic [7:0] DIGIT_BUF;
  logic       WR_REQ;
  logic [2:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       ERR;

  // Keyboard side and RTC controller side, seen from outside the decoder.
  modport master (
    output SCAN_CODE, SCAN_VALID, WR_ACK,
    input  EDIT_MODE, FIELD_SEL, DIGIT_BUF, WR_REQ, WR_ADDR, WR_DATA, ERR
  );

  // The decoder itself.
  modport slave (
    input  SCAN_CODE, SCAN_VALID, WR_ACK,
    output EDIT_MODE, FIELD_SEL, DIGIT_BUF, WR_REQ, WR_ADDR, WR_DATA, ERR
  );
endinterface

// File: rtl/ps2_cmd_decoder.sv
// Purpose: turns released-key PS/2 set-2 scan codes into range-checked BCD writes for a six-field RTC.
// Latency: every output is registered and reacts one Reloj cycle after the SCAN_VALID strobe or WR_ACK.
// Backpressure: while a write waits for WR_ACK, incoming scan codes are dropped and the timeout is frozen.
module ps2_cmd_decoder #(
  parameter int TIMEOUT = 1_000_000_000
) (
  input  logic              Reloj,
  input  logic              RST,
  ps2_cmd_decoder_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EDIT  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  // Timer counts 0..TIMEOUT-1; reaching the last value on a quiet cycle ends the edit session.
  localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMR_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] FIELD_LAST = 3'd5;

  // State and output registers
  logic [1:0]    r_state;
  logic          r_edit_mode;
  logic [2:0]    r_field;
  logic [7:0]    r_buf;
  logic [1:0]    r_cnt;
  logic [TW-1:0] r_tmr;
  logic          r_wr_req;
  logic [2:0]    r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_err;

  // Decoded key classes
  logic       w_is_digit;
  logic [3:0] w_digit;
  logic       w_key_e;
  logic       w_key_enter;
  logic       w_key_esc;
  logic       w_key_left;
  logic       w_key_right;

  // Qualified events
  logic       w_range_ok;
  logic       w_start;
  logic       w_edit_key;
  logic       w_esc;
  logic       w_tmo;
  logic       w_enter;
  logic       w_enter_ok;
  logic       w_enter_bad;
  logic       w_range_fail;
  logic       w_ack;
  logic [2:0] w_field_inc;
  logic [2:0] w_field_dec;
  logic [1:0] w_cnt_inc;

  // Map the recognised scan codes onto key classes; anything else decodes to nothing.
  always_comb begin
    w_is_digit  = 1'b0;
    w_digit     = 4'd0;
    w_key_e     = 1'b0;
    w_key_enter = 1'b0;
    w_key_esc   = 1'b0;
    w_key_left  = 1'b0;
    w_key_right = 1'b0;
    case (bus.SCAN_CODE)
      8'h45: begin w_is_digit = 1'b1; w_digit = 4'd0; end
      8'h16: begin w_is_digit = 1'b1; w_digit = 4'd1; end
      8'h1E: begin w_is_digit = 1'b1; w_digit = 4'd2; end
      8'h26: begin w_is_digit = 1'b1; w_digit = 4'd3; end
      8'h25: begin w_is_digit = 1'b1; w_digit = 4'd4; end
      8'h2E: begin w_is_digit = 1'b1; w_digit = 4'd5; end
      8'h36: begin w_is_digit = 1'b1; w_digit = 4'd6; end
      8'h3D: begin w_is_digit = 1'b1; w_digit = 4'd7; end
      8'h3E: begin w_is_digit = 1'b1; w_digit = 4'd8; end
      8'h46: begin w_is_digit = 1'b1; w_digit = 4'd9; end
      8'h24: w_key_e     = 1'b1;
      8'h5A: w_key_enter = 1'b1;
      8'h76: w_key_esc   = 1'b1;
      8'h6B: w_key_left  = 1'b1;
      8'h74: w_key_right = 1'b1;
      default: ;
    endcase
  end

  // Legal BCD range of the buffer for the field under the cursor; nibbles are always BCD so hex compare works.
  always_comb begin
    w_range_ok = 1'b0;
    case (r_field)
      3'd0, 3'd1: w_range_ok = (r_buf <= 8'h59);
      3'd2:       w_range_ok = (r_buf <= 8'h23);
      3'd3:       w_range_ok = (r_buf >= 8'h01) && (r_buf <= 8'h31);
      3'd4:       w_range_ok = (r_buf >= 8'h01) && (r_buf <= 8'h12);
      3'd5:       w_range_ok = 1'b1;
      default:    w_range_ok = 1'b0;
    endcase
  end

  assign w_start      = (r_state == IDLE) && bus.SCAN_VALID && w_key_e;
  assign w_edit_key   = (r_state == EDIT) && bus.SCAN_VALID;
  assign w_esc        = w_edit_key && w_key_esc;
  assign w_tmo        = (r_state == EDIT) && !bus.SCAN_VALID && (r_tmr == TMR_LAST);
  assign w_enter      = w_edit_key && w_key_enter;
  assign w_enter_ok   = w_enter && (r_cnt != 2'd0) && w_range_ok;
  assign w_enter_bad  = w_enter && ((r_cnt == 2'd0) || !w_range_ok);
  assign w_range_fail = w_enter && (r_cnt != 2'd0) && !w_range_ok;
  // WR_ACK only counts while a request is actually outstanding.
  assign w_ack        = (r_state == WRITE) && r_wr_req && bus.WR_ACK;
  assign w_field_inc  = (r_field == FIELD_LAST) ? 3'd0 : r_field + 3'd1;
  assign w_field_dec  = (r_field == 3'd0) ? FIELD_LAST : r_field - 3'd1;
  assign w_cnt_inc    = (r_cnt == 2'd2) ? 2'd2 : r_cnt + 2'd1;

  // Session control: state, EDIT_MODE flag and inactivity timer (frozen while a write is pending).
  always_ff @(posedge Reloj or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_edit_mode <= 1'b0;
      r_tmr       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= EDIT;
            r_edit_mode <= 1'b1;
            r_tmr       <= '0;
          end
        end
        EDIT: begin
          if (w_esc || w_tmo) begin
            r_state     <= IDLE;
            r_edit_mode <= 1'b0;
            r_tmr       <= '0;
          end else if (w_enter_ok) begin
            r_state <= WRITE;
          end else if (bus.SCAN_VALID) begin
            r_tmr <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        WRITE: begin
          if (w_ack) begin
            r_state <= EDIT;
            r_tmr   <= '0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_edit_mode <= 1'b0;
          r_tmr       <= '0;
        end
      endcase
    end
  end

  // Field cursor, digit buffer and digit count.
  always_ff @(posedge Reloj or posedge RST) begin
    if (RST) begin
      r_field <= 3'd0;
      r_buf   <= 8'h00;
      r_cnt   <= 2'd0;
    end else if (w_start || w_esc || w_tmo) begin
      r_field <= 3'd0;
      r_buf   <= 8'h00;
      r_cnt   <= 2'd0;
    end else if (w_ack) begin
      r_field <= w_field_inc;
      r_buf   <= 8'h00;
      r_cnt   <= 2'd0;
    end else if (w_edit_key) begin
      if (w_is_digit) begin
        r_buf <= {r_buf[3:0], w_digit};
        r_cnt <= w_cnt_inc;
      end else if (w_key_left) begin
        r_field <= w_field_dec;
        r_buf   <= 8'h00;
        r_cnt   <= 2'd0;
      end else if (w_key_right) begin
        r_field <= w_field_inc;
        r_buf   <= 8'h00;
        r_cnt   <= 2'd0;
      end else if (w_range_fail) begin
        r_buf <= 8'h00;
        r_cnt <= 2'd0;
      end
    end
  end

  // Write request: raised with address/data on an accepted Enter, dropped on acknowledge; addr/data hold afterwards.
  always_ff @(posedge Reloj or posedge RST) begin
    if (RST) begin
      r_wr_req  <= 1'b0;
      r_wr_addr <= 3'd0;
      r_wr_data <= 8'h00;
    end else if (w_enter_ok) begin
      r_wr_req  <= 1'b1;
      r_wr_addr <= r_field;
      r_wr_data <= r_buf;
    end else if (w_ack) begin
      r_wr_req <= 1'b0;
    end
  end

  // Single-cycle error pulse on an empty or out-of-range Enter.
  always_ff @(posedge Reloj or posedge RST) begin
    if (RST) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_enter_bad;
    end
  end

  assign bus.EDIT_MODE = r_edit_mode;
  assign bus.FIELD_SEL = r_field;
  assign bus.DIGIT_BUF = r_buf;
  assign bus.WR_REQ    = r_wr_req;
  assign bus.WR_ADDR   = r_wr_addr;
  assign bus.WR_DATA   = r_wr_data;
  assign bus.ERR       = r_err;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Purpose: directed scenarios for the PS/2 command decoder with a short inactivity limit.
// Latency: inputs change 1 ns after a rising edge and outputs are sampled 1 ns after the next one.
// Backpressure: WR_ACK is driven by hand to hold or release pending writes.
module tb_ps2_cmd_decoder;

  localparam logic [7:0] K_E   = 8'h24;
  localparam logic [7:0] K_ENT = 8'h5A;
  localparam logic [7:0] K_ESC = 8'h76;
  localparam logic [7:0] K_LFT = 8'h6B;
  localparam logic [7:0] K_RGT = 8'h74;
  localparam logic [7:0] K_A   = 8'h1C;
  localparam logic [7:0] D0 = 8'h45, D1 = 8'h16, D2 = 8'h1E, D3 = 8'h26, D4 = 8'h25, D5 = 8'h2E;

  logic Reloj;
  logic RST;
  int   n_total;
  int   n_bad;

  ps2_cmd_decoder_if bus_if();

  ps2_cmd_decoder #(.TIMEOUT(16)) dut (
    .Reloj (Reloj),
    .RST   (RST),
    .bus   (bus_if)
  );

  initial Reloj = 1'b0;
  always #5 Reloj = ~Reloj;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Reloj);
    #1;
  endtask

  task automatic key(input logic [7:0] code);
    bus_if.SCAN_CODE  = code;
    bus_if.SCAN_VALID = 1'b1;
    tick(1);
    bus_if.SCAN_VALID = 1'b0;
  endtask

  task automatic ack();
    bus_if.WR_ACK = 1'b1;
    tick(1);
    bus_if.WR_ACK = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    bus_if.SCAN_CODE  = 8'h00;
    bus_if.SCAN_VALID = 1'b0;
    bus_if.WR_ACK     = 1'b0;
    RST = 1'b1;
    tick(3);
    chk_val("rst_edit", bus_if.EDIT_MODE, 1'b0);
    chk_val("rst_field", bus_if.FIELD_SEL, 3'd0);
    chk_val("rst_buf", bus_if.DIGIT_BUF, 8'h00);
    chk_val("rst_req", bus_if.WR_REQ, 1'b0);
    chk_val("rst_addr", bus_if.WR_ADDR, 3'd0);
    chk_val("rst_data", bus_if.WR_DATA, 8'h00);
    chk_val("rst_err", bus_if.ERR, 1'b0);
    RST = 1'b0;
    tick(1);

    // Keys other than E are ignored in IDLE.
    key(D1);
    chk_val("idle_digit_edit", bus_if.EDIT_MODE, 1'b0);
    chk_val("idle_digit_buf", bus_if.DIGIT_BUF, 8'h00);

    // Seconds write of 35, acknowledged after four cycles.
    key(K_E);
    chk_val("s1_edit", bus_if.EDIT_MODE, 1'b1);
    chk_val("s1_field0", bus_if.FIELD_SEL, 3'd0);
    key(D3);
    chk_val("s1_buf03", bus_if.DIGIT_BUF, 8'h03);
    key(D5);
    chk_val("s1_buf35", bus_if.DIGIT_BUF, 8'h35);
    key(K_ENT);
    chk_val("s1_req", bus_if.WR_REQ, 1'b1);
    chk_val("s1_addr", bus_if.WR_ADDR, 3'd0);
    chk_val("s1_data", bus_if.WR_DATA, 8'h35);
    chk_val("s1_edit_wr", bus_if.EDIT_MODE, 1'b1);
    chk_val("s1_err", bus_if.ERR, 1'b0);
    key(D1);
    chk_val("s1_drop_buf", bus_if.DIGIT_BUF, 8'h35);
    tick(2);
    chk_val("s1_req_hold", bus_if.WR_REQ, 1'b1);
    ack();
    chk_val("s1_req_clr", bus_if.WR_REQ, 1'b0);
    chk_val("s1_field1", bus_if.FIELD_SEL, 3'd1);
    chk_val("s1_buf_clr", bus_if.DIGIT_BUF, 8'h00);
    chk_val("s1_addr_hold", bus_if.WR_ADDR, 3'd0);
    chk_val("s1_data_hold", bus_if.WR_DATA, 8'h35);
    chk_val("s1_back_edit", bus_if.EDIT_MODE, 1'b1);
    ack();
    chk_val("s1_stray_ack", bus_if.FIELD_SEL, 3'd1);
    key(K_ESC);
    chk_val("esc_edit", bus_if.EDIT_MODE, 1'b0);
    chk_val("esc_field", bus_if.FIELD_SEL, 3'd0);

    // Hour 25 rejected, empty Enter rejected, then hour 23 accepted with ack racing a digit.
    key(K_E);
    key(K_RGT);
    key(K_RGT);
    chk_val("s2_field2", bus_if.FIELD_SEL, 3'd2);
    key(D2);
    key(D5);
    key(K_ENT);
    chk_val("s2_err", bus_if.ERR, 1'b1);
    chk_val("s2_no_req", bus_if.WR_REQ, 1'b0);
    chk_val("s2_buf_clr", bus_if.DIGIT_BUF, 8'h00);
    chk_val("s2_field_kept", bus_if.FIELD_SEL, 3'd2);
    tick(1);
    chk_val("s2_err_pulse", bus_if.ERR, 1'b0);
    key(K_ENT);
    chk_val("s2_empty_err", bus_if.ERR, 1'b1);
    chk_val("s2_empty_edit", bus_if.EDIT_MODE, 1'b1);
    key(D2);
    key(D3);
    key(K_ENT);
    chk_val("s2_hr_req", bus_if.WR_REQ, 1'b1);
    chk_val("s2_hr_data", bus_if.WR_DATA, 8'h23);
    chk_val("s2_hr_addr", bus_if.WR_ADDR, 3'd2);
    bus_if.WR_ACK = 1'b1;
    key(D1);
    bus_if.WR_ACK = 1'b0;
    chk_val("s2_ack_req", bus_if.WR_REQ, 1'b0);
    chk_val("s2_ack_field", bus_if.FIELD_SEL, 3'd3);
    chk_val("s2_ack_drop", bus_if.DIGIT_BUF, 8'h00);

    // Day 00 rejected, day 10 written to field 3.
    key(D0);
    key(D0);
    key(K_ENT);
    chk_val("s4_day0_err", bus_if.ERR, 1'b1);
    chk_val("s4_day0_req", bus_if.WR_REQ, 1'b0);
    key(D1);
    key(D0);
    key(K_ENT);
    chk_val("s4_day_req", bus_if.WR_REQ, 1'b1);
    chk_val("s4_day_addr", bus_if.WR_ADDR, 3'd3);
    chk_val("s4_day_data", bus_if.WR_DATA, 8'h10);
    ack();
    chk_val("s4_field4", bus_if.FIELD_SEL, 3'd4);

    // Month 13 rejected; three digits keep shifting, month 12 written; cursor wraps 5 -> 0.
    key(D1);
    key(D3);
    key(K_ENT);
    chk_val("mon13_err", bus_if.ERR, 1'b1);
    key(D0);
    key(D1);
    key(D2);
    chk_val("third_digit", bus_if.DIGIT_BUF, 8'h12);
    key(K_ENT);
    chk_val("mon12_data", bus_if.WR_DATA, 8'h12);
    chk_val("mon12_addr", bus_if.WR_ADDR, 3'd4);
    ack();
    chk_val("field5", bus_if.FIELD_SEL, 3'd5);
    key(K_RGT);
    chk_val("wrap_right", bus_if.FIELD_SEL, 3'd0);
    key(K_ESC);

    // Left wraps to 5, E ignored inside EDIT, unknown code ignored.
    key(K_E);
    key(K_LFT);
    chk_val("s3_left", bus_if.FIELD_SEL, 3'd5);
    key(K_RGT);
    chk_val("s3_right", bus_if.FIELD_SEL, 3'd0);
    key(K_E);
    key(D1);
    key(D2);
    key(D3);
    chk_val("s3_buf23", bus_if.DIGIT_BUF, 8'h23);
    key(K_A);
    chk_val("s3_unknown", bus_if.DIGIT_BUF, 8'h23);
    chk_val("s3_unknown_edit", bus_if.EDIT_MODE, 1'b1);
    key(K_ESC);
    chk_val("s3_esc_buf", bus_if.DIGIT_BUF, 8'h00);

    // Inactivity limit of 16 cycles, and restart by a key at cycle 15.
    key(K_E);
    tick(15);
    chk_val("tmo_15", bus_if.EDIT_MODE, 1'b1);
    tick(1);
    chk_val("tmo_16", bus_if.EDIT_MODE, 1'b0);
    key(K_E);
    tick(14);
    key(K_A);
    tick(15);
    chk_val("tmo_restart_hold", bus_if.EDIT_MODE, 1'b1);
    tick(1);
    chk_val("tmo_restart_exp", bus_if.EDIT_MODE, 1'b0);

    // Asynchronous reset during a pending write.
    key(K_E);
    key(D4);
    key(D5);
    key(K_ENT);
    chk_val("s6_req", bus_if.WR_REQ, 1'b1);
    #1;
    RST = 1'b1;
    #1;
    chk_val("s6_async_req", bus_if.WR_REQ, 1'b0);
    chk_val("s6_async_edit", bus_if.EDIT_MODE, 1'b0);
    chk_val("s6_async_data", bus_if.WR_DATA, 8'h00);
    #1;
    RST = 1'b0;
    tick(1);
    ack();
    chk_val("s6_ack_req", bus_if.WR_REQ, 1'b0);
    chk_val("s6_ack_edit", bus_if.EDIT_MODE, 1'b0);
    chk_val("s6_ack_field", bus_if.FIELD_SEL, 3'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
